// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_pkg;

    localparam int REG_AW_DEFAULT = 3;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef struct packed {
        logic                      valid;
        logic [REG_AW_DEFAULT-1:0] rd;
        logic                      wr;
        logic                      load;
        logic                      mul;
    } stage_t;

    localparam stage_t STAGE_NOP = '0;

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - operand forward-select comparator for one EX source
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [REG_AW_DEFAULT-1:0] rs,
    input  stage_t                    mem,
    input  stage_t                    wb,
    output logic [1:0]                sel
);

    // A load in MEM has no ALU result yet, so only MEM/WB can supply it.
    always_comb begin
        sel = FWD_REG;
        if (mem.valid && mem.wr && !mem.load && (mem.rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (wb.valid && wb.wr && (wb.rd == rs)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall, flush, MUL hold and forwarding control for a 5-stage pipeline
module hazard_controller
    import pipe_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEFAULT,
    parameter int MUL_LAT = 3,
    parameter int PCNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr,
    input  logic              id_load,
    input  logic              id_mul,
    input  logic              ex_branch_taken,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_hold,
    output logic              ex_mem_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [PCNT_W-1:0] stall_cnt,
    output logic [PCNT_W-1:0] flush_cnt
);

    localparam logic [3:0] MUL_LOAD = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;
    localparam logic [PCNT_W-1:0] CNT_MAX = '1;

    state_t            state, next_state;
    logic [3:0]        mul_cnt;
    stage_t            ex_st, mem_st, wb_st;
    logic [REG_AW-1:0] ex_rs1, ex_rs2;
    logic              branch, load_use;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Branch squashes the dependent ID instruction, so it outranks load-use.
    always_comb begin
        next_state    = state;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_hold       = 1'b0;
        ex_mem_bubble = 1'b0;
        branch        = !reset && (state == RUN) && ex_branch_taken;
        load_use      = !reset && id_valid && ex_st.valid && ex_st.load && ex_st.wr &&
                        ((id_use_rs1 && (ex_st.rd == id_rs1)) ||
                         (id_use_rs2 && (ex_st.rd == id_rs2)));
        if (reset) begin
            next_state = RUN;
        end else if (state == MUL_BUSY) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            ex_hold       = 1'b1;
            ex_mem_bubble = 1'b1;
            if (mul_cnt == 4'd0) begin
                next_state = RUN;
            end
        end else begin
            if (branch) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (load_use) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            if (ex_st.valid && ex_st.mul && (MUL_LAT > 1)) begin
                next_state = MUL_BUSY;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_cnt   <= 4'd0;
            ex_st     <= STAGE_NOP;
            mem_st    <= STAGE_NOP;
            wb_st     <= STAGE_NOP;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state != MUL_BUSY) begin
                if (id_ex_bubble || !id_valid) begin
                    ex_st <= STAGE_NOP;
                end else begin
                    ex_st <= stage_t'{valid: 1'b1, rd: id_rd, wr: id_wr,
                                      load: id_load, mul: id_mul};
                end
                ex_rs1 <= id_rs1;
                ex_rs2 <= id_rs2;
                mem_st <= ex_mem_bubble ? STAGE_NOP : ex_st;
                wb_st  <= mem_st;
            end
            if ((state == RUN) && (next_state == MUL_BUSY)) begin
                mul_cnt <= MUL_LOAD;
            end else if ((state == MUL_BUSY) && (mul_cnt != 4'd0)) begin
                mul_cnt <= mul_cnt - 4'd1;
            end
            if (pc_stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (branch && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    fwd_unit u_fwd_a (
        .rs  (ex_rs1),
        .mem (mem_st),
        .wb  (wb_st),
        .sel (fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs  (ex_rs2),
        .mem (mem_st),
        .wb  (wb_st),
        .sel (fwd_b)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - self-checking bench for hazard_controller
module tb_hazard_controller;

    localparam int MUL_LAT = 3;
    localparam int PCNT_W  = 2;
    localparam int CMAX    = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs1, id_use_rs2, id_wr, id_load, id_mul, ex_branch_taken;
    logic [2:0] id_rs1, id_rs2, id_rd;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, ex_mem_bubble;
    logic [1:0] fwd_a, fwd_b;
    logic [PCNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_controller #(.REG_AW(3), .MUL_LAT(MUL_LAT), .PCNT_W(PCNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load), .id_mul(id_mul),
        .ex_branch_taken(ex_branch_taken),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold), .ex_mem_bubble(ex_mem_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, ex_mem_bubble, fwd_a, fwd_b}
    wire [9:0] obs_ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
                          ex_hold, ex_mem_bubble, fwd_a, fwd_b};

    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
        bit mu;
        int rs1;
        int rs2;
    } ins_t;

    ins_t       pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
    int         busy_left;
    int         n_stall, n_flush;
    logic [9:0] exp_ctl;
    int         checks = 0;
    int         errors = 0;

    function automatic int fwd_of(int rs);
        if (pipe[1].v && pipe[1].wr && !pipe[1].ld && pipe[1].rd == rs) return 1;
        if (pipe[2].v && pipe[2].wr && pipe[2].rd == rs) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            pipe[i].v = 0; pipe[i].rd = 0; pipe[i].wr = 0; pipe[i].ld = 0;
            pipe[i].mu = 0; pipe[i].rs1 = 0; pipe[i].rs2 = 0;
        end
        busy_left = 0;
        n_stall   = 0;
        n_flush   = 0;
    endtask

    task automatic model_eval();
        bit busy, br, lu, ps, bub;
        busy = busy_left > 0;
        br   = !busy && ex_branch_taken;
        lu   = id_valid && pipe[0].v && pipe[0].ld && pipe[0].wr &&
               ((id_use_rs1 && pipe[0].rd == int'(id_rs1)) ||
                (id_use_rs2 && pipe[0].rd == int'(id_rs2)));
        ps   = busy || (!br && lu);
        bub  = !busy && (br || lu);
        exp_ctl = {ps, ps, br, bub, busy, busy,
                   2'(fwd_of(pipe[0].rs1)), 2'(fwd_of(pipe[0].rs2))};
    endtask

    task automatic model_tick();
        ins_t nx;
        bit   enter;
        if (exp_ctl[9] && n_stall < CMAX) n_stall++;
        if (exp_ctl[7] && n_flush < CMAX) n_flush++;
        if (busy_left > 0) begin
            busy_left--;
        end else begin
            enter = pipe[0].v && pipe[0].mu && (MUL_LAT > 1);
            nx.v  = id_valid && !exp_ctl[6];
            nx.rd = nx.v ? int'(id_rd) : 0;
            nx.wr = nx.v && id_wr;
            nx.ld = nx.v && id_load;
            nx.mu = nx.v && id_mul;
            nx.rs1 = int'(id_rs1);
            nx.rs2 = int'(id_rs2);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nx;
            if (enter) busy_left = MUL_LAT - 1;
        end
    endtask

    task automatic set_in(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit wr, input bit ld, input bit mu, input bit br);
        id_valid = v; id_rs1 = 3'(rs1); id_use_rs1 = u1; id_rs2 = 3'(rs2); id_use_rs2 = u2;
        id_rd = 3'(rd); id_wr = wr; id_load = ld; id_mul = mu; ex_branch_taken = br;
        model_eval();
        #1;
    endtask

    task automatic set_idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        set_idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1, 1, 1, 2, 1, 3, 1, 1, 1, 1);
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs_ctl !== 10'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", obs_ctl, 10'b0);
        end
        checks++;
        if ({stall_cnt, flush_cnt} !== 4'b0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
        reset = 1'b0;
        set_idle();
        checks++;
        if (obs_ctl !== 10'b0) begin
            errors++; $display("FAIL post_reset_outputs: got %b expected %b", obs_ctl, 10'b0);
        end
    endtask

    task automatic test_fwd_exmem();
        do_reset();
        set_in(1, 2, 1, 3, 1, 1, 1, 0, 0, 0);
        tick();
        set_in(1, 1, 1, 3, 1, 2, 1, 0, 0, 0);
        tick();
        set_idle();
        checks++;
        if (obs_ctl !== 10'b000000_01_00) begin
            errors++; $display("FAIL fwd_exmem: got %b expected %b", obs_ctl, 10'b000000_01_00);
        end
        checks++;
        if (stall_cnt !== 2'd0) begin
            errors++; $display("FAIL fwd_exmem_stall_cnt: got %0d expected 0", stall_cnt);
        end
    endtask

    task automatic test_fwd_memwb();
        do_reset();
        set_in(1, 2, 1, 3, 1, 1, 1, 0, 0, 0);
        tick();
        set_in(1, 2, 1, 3, 1, 7, 1, 0, 0, 0);
        tick();
        set_in(1, 1, 1, 1, 1, 4, 1, 0, 0, 0);
        tick();
        set_idle();
        checks++;
        if (obs_ctl !== 10'b000000_10_10) begin
            errors++; $display("FAIL fwd_memwb: got %b expected %b", obs_ctl, 10'b000000_10_10);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(1, 0, 1, 0, 0, 5, 1, 1, 0, 0);
        tick();
        set_in(1, 5, 1, 0, 1, 6, 1, 0, 0, 0);
        checks++;
        if (obs_ctl !== 10'b110100_00_00) begin
            errors++; $display("FAIL load_use_stall: got %b expected %b", obs_ctl, 10'b110100_00_00);
        end
        tick();
        set_in(1, 5, 1, 0, 1, 6, 1, 0, 0, 0);
        checks++;
        if (obs_ctl[9:4] !== 6'b0) begin
            errors++; $display("FAIL load_use_single: got %b expected %b", obs_ctl[9:4], 6'b0);
        end
        tick();
        set_idle();
        checks++;
        if (obs_ctl !== 10'b000000_10_00) begin
            errors++; $display("FAIL load_use_fwd: got %b expected %b", obs_ctl, 10'b000000_10_00);
        end
        checks++;
        if (stall_cnt !== 2'd1) begin
            errors++; $display("FAIL load_use_stall_cnt: got %0d expected 1", stall_cnt);
        end
    endtask

    task automatic test_mul();
        do_reset();
        set_in(1, 3, 1, 4, 1, 2, 1, 0, 1, 0);
        tick();
        set_idle();
        checks++;
        if (obs_ctl !== 10'b0) begin
            errors++; $display("FAIL mul_enter: got %b expected %b", obs_ctl, 10'b0);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            set_idle();
            checks++;
            if (obs_ctl !== 10'b110011_00_00) begin
                errors++; $display("FAIL mul_busy%0d: got %b expected %b", c, obs_ctl, 10'b110011_00_00);
            end
        end
        tick();
        set_idle();
        checks++;
        if (obs_ctl !== 10'b0) begin
            errors++; $display("FAIL mul_exit: got %b expected %b", obs_ctl, 10'b0);
        end
        checks++;
        if (stall_cnt !== 2'd2) begin
            errors++; $display("FAIL mul_stall_cnt: got %0d expected 2", stall_cnt);
        end
    endtask

    task automatic test_branch();
        do_reset();
        set_in(1, 0, 1, 0, 0, 5, 1, 1, 0, 0);
        tick();
        set_in(1, 5, 1, 0, 1, 6, 1, 0, 0, 1);
        checks++;
        if (obs_ctl !== 10'b001100_00_00) begin
            errors++; $display("FAIL branch_flush: got %b expected %b", obs_ctl, 10'b001100_00_00);
        end
        tick();
        set_idle();
        checks++;
        if ({stall_cnt, flush_cnt} !== {2'd0, 2'd1}) begin
            errors++; $display("FAIL branch_counters: got %0d/%0d expected 0/1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_reset_mid_mul();
        do_reset();
        set_in(1, 3, 1, 4, 1, 2, 1, 0, 1, 0);
        tick();
        set_idle();
        tick();
        set_idle();
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (ex_hold !== 1'b1 || stall_cnt !== 2'd1) begin
            errors++; $display("FAIL mid_mul_busy: got hold=%b cnt=%0d expected hold=1 cnt=1", ex_hold, stall_cnt);
        end
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({obs_ctl, stall_cnt, flush_cnt} !== 14'b0) begin
            errors++; $display("FAIL mid_mul_reset: got %b/%0d/%0d expected all 0", obs_ctl, stall_cnt, flush_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        set_idle();
        tick();
        set_idle();
        checks++;
        if (obs_ctl !== 10'b0) begin
            errors++; $display("FAIL mid_mul_run: got %b expected %b", obs_ctl, 10'b0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int m = 0; m < 2; m++) begin
            set_in(1, 3, 1, 4, 1, 2, 1, 0, 1, 0);
            tick();
            repeat (3) begin
                set_idle();
                tick();
            end
        end
        set_idle();
        checks++;
        if (stall_cnt !== 2'd3) begin
            errors++; $display("FAIL stall_saturate: got %0d expected 3", stall_cnt);
        end
        repeat (5) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            tick();
        end
        set_idle();
        checks++;
        if ({stall_cnt, flush_cnt} !== {2'd3, 2'd3}) begin
            errors++; $display("FAIL flush_saturate: got %0d/%0d expected 3/3", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_random();
        logic [9:0] mask;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            mask = pipe[0].v ? 10'h3ff : 10'h3f0;
            checks++;
            if ((obs_ctl & mask) !== (exp_ctl & mask)) begin
                errors++; $display("FAIL random_ctl c%0d: got %b expected %b", c, obs_ctl & mask, exp_ctl & mask);
            end
            tick();
            checks++;
            if ({stall_cnt, flush_cnt} !== {2'(n_stall), 2'(n_flush)}) begin
                errors++; $display("FAIL random_cnt c%0d: got %0d/%0d expected %0d/%0d", c, stall_cnt, flush_cnt, n_stall, n_flush);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fwd_exmem();
        test_fwd_memwb();
        test_load_use();
        test_mul();
        test_branch();
        test_reset_mid_mul();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
